// File: rtl/registro_pkg.sv
// Shared sizing helpers and types for the registro_* register-buffer blocks.
package registro_pkg;

  localparam int unsigned DefaultDepth = 4;

  // A single-entry store still needs one pointer bit to stay a legal vector.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [ptr_width(DefaultDepth)-1:0] ptr_t;

endpackage

// File: rtl/registro_ptr.sv
// Wrap-around index into a DEPTH-entry store; advances on inc_i, wraps after DEPTH-1.
module registro_ptr
  import registro_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          inc_i,
  output logic [ptr_width(DEPTH)-1:0]   ptr_o
);

  localparam int unsigned PtrW = ptr_width(DEPTH);

  logic [PtrW-1:0] ptr_q, ptr_d;

  // Explicit compare so non-power-of-2 depths wrap correctly.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = (ptr_q == PtrW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/registro_fifo.sv
// Show-ahead register FIFO with registered occupancy status and overflow/underflow pulses.
module registro_fifo
  import registro_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [N-1:0]                 data_i,
  output logic [N-1:0]                 data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [cnt_width(DEPTH)-1:0]  count_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = cnt_width(DEPTH);

  logic [N-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, empty_q, overflow_q, underflow_q;
  logic            push_ok, pop_ok;

  // A push into a full store is legal only when a pop frees the head the same cycle.
  always_comb begin
    pop_ok  = pop_i && !empty_q;
    push_ok = push_i && (!full_q || pop_ok);
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      full_q      <= (count_d == CntW'(DEPTH));
      empty_q     <= (count_d == '0);
      overflow_q  <= push_i && !push_ok;
      underflow_q <= pop_i && empty_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr] <= data_i;
    end
  end

  registro_ptr #(
    .DEPTH (DEPTH)
  ) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (push_ok),
    .ptr_o (wr_ptr)
  );

  registro_ptr #(
    .DEPTH (DEPTH)
  ) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (pop_ok),
    .ptr_o (rd_ptr)
  );

  // Storage is never cleared, so the head is masked while nothing valid is held.
  assign data_o      = empty_q ? '0 : mem_q[rd_ptr];
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_registro_fifo.sv
// Bench for registro_fifo: an 8x4 and a 16x3 instance driven in lock-step, checked
// against constant vectors and a queue-based reference model.
module tb_registro_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push, pop;
  logic [7:0]  data8;
  logic [15:0] data16;

  logic [7:0]  dout4;
  logic        full4, empty4, ovf4, unf4;
  logic [2:0]  cnt4;
  logic [15:0] dout3;
  logic        full3, empty3, ovf3, unf3;
  logic [1:0]  cnt3;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  q4[$];
  logic [15:0] q3[$];
  bit          e_ovf4, e_unf4, e_ovf3, e_unf3;

  always #5 clk = ~clk;

  registro_fifo #(.N(8), .DEPTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .push_i(push), .pop_i(pop), .data_i(data8),
    .data_o(dout4), .full_o(full4), .empty_o(empty4), .count_o(cnt4),
    .overflow_o(ovf4), .underflow_o(unf4)
  );

  registro_fifo #(.N(16), .DEPTH(3)) dut3 (
    .clk_i(clk), .rst_i(rst_n), .push_i(push), .pop_i(pop), .data_i(data16),
    .data_o(dout3), .full_o(full3), .empty_o(empty3), .count_o(cnt3),
    .overflow_o(ovf3), .underflow_o(unf3)
  );

  typedef struct {
    bit         push;
    bit         pop;
    logic [7:0] data;
    logic [7:0] exp_data;
    int         exp_count;
    bit         exp_full;
    bit         exp_empty;
    bit         exp_ovf;
    bit         exp_unf;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(bit p, bit r, logic [7:0] d, logic [7:0] ed, int ec,
                              bit ef, bit ee, bit eo, bit eu);
    vec_t v;
    v.push = p; v.pop = r; v.data = d; v.exp_data = ed; v.exp_count = ec;
    v.exp_full = ef; v.exp_empty = ee; v.exp_ovf = eo; v.exp_unf = eu;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Occupancy rules from the buffer's contract, expressed on queue size only.
  task automatic rules(input int size, input int depth, input bit p, input bit r,
                       output bit push_acc, output bit pop_acc, output bit ovf,
                       output bit unf);
    pop_acc  = r && (size > 0);
    push_acc = p && ((size < depth) || pop_acc);
    ovf      = p && !push_acc;
    unf      = r && (size == 0);
  endtask

  task automatic check_model();
    chk("d4_data",  32'(dout4),  q4.size() > 0 ? 32'(q4[0]) : 32'h0);
    chk("d4_count", 32'(cnt4),   32'(q4.size()));
    chk("d4_full",  32'(full4),  32'(q4.size() == 4));
    chk("d4_empty", 32'(empty4), 32'(q4.size() == 0));
    chk("d4_ovf",   32'(ovf4),   32'(e_ovf4));
    chk("d4_unf",   32'(unf4),   32'(e_unf4));
    chk("d3_data",  32'(dout3),  q3.size() > 0 ? 32'(q3[0]) : 32'h0);
    chk("d3_count", 32'(cnt3),   32'(q3.size()));
    chk("d3_full",  32'(full3),  32'(q3.size() == 3));
    chk("d3_empty", 32'(empty3), 32'(q3.size() == 0));
    chk("d3_ovf",   32'(ovf3),   32'(e_ovf3));
    chk("d3_unf",   32'(unf3),   32'(e_unf3));
    chk("d3_max",   32'(cnt3 <= 2'd3), 32'h1);
  endtask

  // Drive one cycle from a negedge, update the model at the posedge, check at the negedge.
  task automatic step(input bit p, input bit r, input logic [7:0] d);
    bit pa, oa;
    push = p; pop = r; data8 = d; data16 = {d, ~d};
    @(posedge clk);
    rules(q4.size(), 4, p, r, pa, oa, e_ovf4, e_unf4);
    if (oa) void'(q4.pop_front());
    if (pa) q4.push_back(d);
    rules(q3.size(), 3, p, r, pa, oa, e_ovf3, e_unf3);
    if (oa) void'(q3.pop_front());
    if (pa) q3.push_back({d, ~d});
    @(negedge clk);
    check_model();
  endtask

  task automatic clear_model();
    q4.delete(); q3.delete();
    e_ovf4 = 0; e_unf4 = 0; e_ovf3 = 0; e_unf3 = 0;
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 8'h11, 8'h11, 1, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 8'h22, 8'h11, 2, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 8'h33, 8'h11, 3, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 8'h44, 8'h11, 4, 1, 0, 0, 0);
    tbl[4]  = mk(1, 0, 8'h55, 8'h11, 4, 1, 0, 1, 0);
    tbl[5]  = mk(0, 0, 8'h00, 8'h11, 4, 1, 0, 0, 0);
    tbl[6]  = mk(0, 1, 8'h00, 8'h22, 3, 0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 8'h00, 8'h33, 2, 0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 8'h00, 8'h44, 1, 0, 0, 0, 0);
    tbl[9]  = mk(0, 1, 8'h00, 8'h00, 0, 0, 1, 0, 0);
    tbl[10] = mk(0, 1, 8'h00, 8'h00, 0, 0, 1, 0, 1);
    tbl[11] = mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0);
    tbl[12] = mk(1, 1, 8'hA5, 8'hA5, 1, 0, 0, 0, 1);
    tbl[13] = mk(1, 0, 8'h11, 8'hA5, 2, 0, 0, 0, 0);
    tbl[14] = mk(1, 0, 8'h22, 8'hA5, 3, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 8'h33, 8'hA5, 4, 1, 0, 0, 0);
    tbl[16] = mk(1, 1, 8'h55, 8'h11, 4, 1, 0, 0, 0);
    tbl[17] = mk(0, 1, 8'h00, 8'h22, 3, 0, 0, 0, 0);
    tbl[18] = mk(0, 1, 8'h00, 8'h33, 2, 0, 0, 0, 0);
    tbl[19] = mk(0, 1, 8'h00, 8'h55, 1, 0, 0, 0, 0);
    tbl[20] = mk(0, 1, 8'h00, 8'h00, 0, 0, 1, 0, 0);

    rst_n = 1'b0; push = 1'b0; pop = 1'b0; data8 = '0; data16 = '0;
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(cnt4),   32'h0);
    chk("rst_empty", 32'(empty4), 32'h1);
    chk("rst_full",  32'(full4),  32'h0);
    chk("rst_data",  32'(dout4),  32'h0);
    chk("rst_flags", 32'({ovf4, unf4, ovf3, unf3}), 32'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].push, tbl[i].pop, tbl[i].data);
      chk("vec_data",  32'(dout4),  32'(tbl[i].exp_data));
      chk("vec_count", 32'(cnt4),   32'(tbl[i].exp_count));
      chk("vec_full",  32'(full4),  32'(tbl[i].exp_full));
      chk("vec_empty", 32'(empty4), 32'(tbl[i].exp_empty));
      chk("vec_ovf",   32'(ovf4),   32'(tbl[i].exp_ovf));
      chk("vec_unf",   32'(unf4),   32'(tbl[i].exp_unf));
    end

    // Pointer wrap with two entries in flight.
    step(1, 0, 8'h00);
    step(1, 0, 8'h01);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 8'(i + 2));
      chk("wrap_count", 32'(cnt4),  32'h2);
      chk("wrap_data",  32'(dout4), 32'(i + 1));
    end

    // Asynchronous reset between edges with three entries held.
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    step(1, 0, 8'h61);
    step(1, 0, 8'h62);
    step(1, 0, 8'h63);
    chk("pre_rst_count", 32'(cnt4), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(cnt4),   32'h0);
    chk("arst_empty", 32'(empty4), 32'h1);
    chk("arst_data",  32'(dout4),  32'h0);
    chk("arst_cnt3",  32'(cnt3),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    step(1, 0, 8'h77);
    chk("post_rst_data",  32'(dout4), 32'h77);
    chk("post_rst_count", 32'(cnt4),  32'h1);

    // Random traffic: fill-biased phase, then drain-biased phase.
    for (int i = 0; i < 400; i++) begin
      int pp, pr;
      pp = (i < 200) ? 65 : 35;
      pr = (i < 200) ? 35 : 65;
      step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < pr, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
